// File: rtl/dmem_lsu_if.sv
// Load/store request and response bundle between the MEM stage and dmem_lsu.
// Latency: none, wires only. Backpressure: none, the slave accepts a request every cycle.
interface dmem_lsu_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 req_valid;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_valid, rsp_rdata, rsp_err, err_count
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_valid, rsp_rdata, rsp_err, err_count
    );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressable little-endian data memory with SB/SH/SW and LB/LH/LW/LBU/LHU; define DMEM_BOUNDS_CHECK_EN to flag addresses >= MEM_BYTES.
// Latency: store bytes land at the request edge, and the response is registered one cycle later.
// Backpressure: none; the memory is always ready and accepts one request per cycle.
module dmem_lsu #(
    parameter int MEM_BYTES = 256,
    parameter int ERR_CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    dmem_lsu_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0] mem [0:MEM_BYTES-1];

    logic [AW-1:0]        idx0, idx1, idx2, idx3;
    logic                 misalign, oob, req_err, wr_en;
    logic [31:0]          ld_raw, ld_ext;

    logic                 rsp_valid_d, rsp_valid_q;
    logic                 rsp_err_d, rsp_err_q;
    logic [31:0]          rsp_rdata_d, rsp_rdata_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |bus.req_addr[31:AW];
`else
    // Upper address bits are intentionally ignored so accesses wrap modulo MEM_BYTES.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW];
    assign oob = 1'b0;
`endif

    always_comb begin
        idx0 = bus.req_addr[AW-1:0];
        idx1 = idx0 + AW'(1);
        idx2 = idx0 + AW'(2);
        idx3 = idx0 + AW'(3);

        misalign = 1'b0;
        case (bus.req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.req_addr[0];
            2'b10:   misalign = |bus.req_addr[1:0];
            default: misalign = 1'b1;
        endcase

        req_err = misalign | oob;
        wr_en   = bus.req_valid & bus.req_we & ~req_err;

        ld_raw = {mem[idx3], mem[idx2], mem[idx1], mem[idx0]};
        ld_ext = ld_raw;
        case (bus.req_size)
            2'b00:   ld_ext = bus.req_unsigned ? {24'd0, ld_raw[7:0]}
                                               : {{24{ld_raw[7]}}, ld_raw[7:0]};
            2'b01:   ld_ext = bus.req_unsigned ? {16'd0, ld_raw[15:0]}
                                               : {{16{ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase

        rsp_valid_d = bus.req_valid;
        rsp_err_d   = bus.req_valid & req_err;
        rsp_rdata_d = (bus.req_valid & ~bus.req_we & ~req_err) ? ld_ext : 32'd0;
        err_cnt_d   = err_cnt_q;
        if (bus.req_valid && req_err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Memory contents survive reset so the array can be preloaded.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[idx0] <= bus.req_wdata[7:0];
            if (bus.req_size != 2'b00) begin
                mem[idx1] <= bus.req_wdata[15:8];
            end
            if (bus.req_size == 2'b10) begin
                mem[idx2] <= bus.req_wdata[23:16];
                mem[idx3] <= bus.req_wdata[31:24];
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed plus randomized bench for dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;
    localparam int MB  = 256;
    localparam int ECW = 8;
    localparam int CNT_MAX = (1 << ECW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_lsu_if #(.ERR_CNT_W(ECW)) bus ();

    dmem_lsu #(.MEM_BYTES(MB), .ERR_CNT_W(ECW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    bit [7:0] ref_mem [MB];
    bit       ref_known [MB];
    int       exp_cnt = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        bit e;
        e = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
        if (a >= MB) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
        bit          e;
        int unsigned n;
        longint      v;
        logic [31:0] exp_rd;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        e      = model_err(sz, a);
        exp_rd = 32'd0;
        n      = 1 << sz;
        if (e) begin
            if (exp_cnt < CNT_MAX) exp_cnt++;
        end else if (we) begin
            for (int i = 0; i < int'(n); i++) begin
                ref_mem[(a + i) % MB]   = 8'((wd >> (8 * i)) & 32'hFF);
                ref_known[(a + i) % MB] = 1'b1;
            end
        end else begin
            v = 0;
            for (int i = 0; i < int'(n); i++) v = v + (longint'(ref_mem[(a + i) % MB]) << (8 * i));
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            exp_rd = v[31:0];
        end
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".err"},   32'(bus.rsp_err),   32'(e));
        check({tag, ".rdata"}, bus.rsp_rdata,      exp_rd);
        check({tag, ".cnt"},   32'(bus.err_count), 32'(exp_cnt));
        last_rdata = bus.rsp_rdata;
    endtask

    task automatic do_idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle.valid", 32'(bus.rsp_valid), 32'd0);
        check("idle.err",   32'(bus.rsp_err),   32'd0);
        check("idle.rdata", bus.rsp_rdata,      32'd0);
        check("idle.cnt",   32'(bus.err_count), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_cnt = 0;
        check("rst.valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.err",   32'(bus.rsp_err),   32'd0);
        check("rst.rdata", bus.rsp_rdata,      32'd0);
        check("rst.cnt",   32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_mem(input string tag, input int a, input logic [7:0] exp);
        check(tag, 32'(dut.mem[a]), 32'(exp));
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        logic [1:0]  sz;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        do_reset();

        // Fill memory with known random words so later loads are fully predictable.
        for (int i = 0; i < MB; i += 4) do_req("fill", 1'b1, 2'd2, 1'b0, 32'(i), $urandom);

        do_req("t1_sw", 1'b1, 2'd2, 1'b0, 32'd4, 32'h0F0F0F0D);
        do_req("t1_lw", 1'b0, 2'd2, 1'b0, 32'd4, 32'd0);
        check("t1_lw_const", last_rdata, 32'h0F0F0F0D);
        check_mem("t1_mem4", 4, 8'h0D);
        check_mem("t1_mem5", 5, 8'h0F);
        check_mem("t1_mem7", 7, 8'h0F);

        do_req("t2_sh", 1'b1, 2'd1, 1'b0, 32'd20, 32'h0000FFFE);
        do_req("t2_lh", 1'b0, 2'd1, 1'b0, 32'd20, 32'd0);
        check("t2_lh_const", last_rdata, 32'hFFFFFFFE);
        do_req("t2_lhu", 1'b0, 2'd1, 1'b1, 32'd20, 32'd0);
        check("t2_lhu_const", last_rdata, 32'h0000FFFE);
        do_req("t2_sb", 1'b1, 2'd0, 1'b0, 32'd22, 32'h00000001);
        do_req("t2_lb", 1'b0, 2'd0, 1'b0, 32'd22, 32'd0);
        check("t2_lb_const", last_rdata, 32'h00000001);

        do_req("t3_lw2", 1'b0, 2'd2, 1'b0, 32'd2, 32'd0);
        do_req("t3_sh21", 1'b1, 2'd1, 1'b0, 32'd21, 32'h00001234);
        check("t3_cnt_const", 32'(bus.err_count), 32'd2);
        for (int i = 20; i < 24; i++) check_mem("t3_mem", i, ref_mem[i]);

        do_idle();

        do_req("t5_sw", 1'b1, 2'd2, 1'b0, 32'(MB), 32'h11223344);
`ifdef DMEM_BOUNDS_CHECK_EN
        check("t5_err_const", 32'(bus.rsp_err), 32'd1);
`else
        check("t5_err_const", 32'(bus.rsp_err), 32'd0);
        check_mem("t5_mem0", 0, 8'h44);
        check_mem("t5_mem3", 3, 8'h11);
`endif
        for (int i = 0; i < 4; i++) check_mem("t5_mem", i, ref_mem[i]);

        // Store presented while reset is high must be dropped entirely.
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 32'd8; bus.req_wdata = ~{ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]};
        @(posedge clk);
        #1;
        exp_cnt = 0;
        check("t4_valid", 32'(bus.rsp_valid), 32'd0);
        check("t4_cnt",   32'(bus.err_count), 32'd0);
        for (int i = 8; i < 12; i++) check_mem("t4_mem", i, ref_mem[i]);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_idle();
            end else begin
                sz = 2'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, 2 * MB - 1));
                if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
                w  = $urandom;
                do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, w);
            end
        end
        for (int i = 0; i < MB; i++) if (ref_known[i]) check_mem("rnd_mem", i, ref_mem[i]);

        do_reset();
        for (int k = 0; k < CNT_MAX + 4; k++) do_req("t6_sat", 1'b0, 2'd1, 1'b0, 32'd1, 32'd0);
        check("t6_cnt_const", 32'(bus.err_count), 32'(CNT_MAX));
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
